freq_sel: RTL

Front-panel frequency selector feeding the clock divider's `freq[25:0]` input. It synchronises and debounces two active-low pushbuttons. It steps a 1-2-5 frequency table up or down per press, auto-repeats while a button is held, and presents a registered, never-zero `freq` word. This guarantees the downstream `50000000/freq` division is always legal.

---
 rtl/freq_sel.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/freq_sel.sv
// Front-panel 1-2-5 frequency selector: synchronises and debounces two active-low
// buttons, steps/auto-repeats a saturating table index and registers a never-zero freq.
module freq_sel #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int HOLD_CYC     = 25000000,
  parameter int REPEAT_CYC   = 5000000,
  parameter int DEFAULT_IDX  = 1
) (
  input  logic        clkIn,
  input  logic        rst,
  input  logic        keyUp_n,
  input  logic        keyDn_n,
  output logic [25:0] freq,
  output logic [4:0]  idx,
  output logic        chg,
  output logic        atMin,
  output logic        atMax
);

  localparam int          MAX_IDX = 22;
  localparam int          DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam int          HC_MAX  = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int          HC_W    = $clog2(HC_MAX + 1);
  localparam logic [4:0]  DEF_IDX = 5'(DEFAULT_IDX);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, BOTH} state_t;

  function automatic logic [25:0] freqOf(input logic [4:0] i);
    case (i)
      5'd0:    return 26'd1;
      5'd1:    return 26'd2;
      5'd2:    return 26'd5;
      5'd3:    return 26'd10;
      5'd4:    return 26'd20;
      5'd5:    return 26'd50;
      5'd6:    return 26'd100;
      5'd7:    return 26'd200;
      5'd8:    return 26'd500;
      5'd9:    return 26'd1000;
      5'd10:   return 26'd2000;
      5'd11:   return 26'd5000;
      5'd12:   return 26'd10000;
      5'd13:   return 26'd20000;
      5'd14:   return 26'd50000;
      5'd15:   return 26'd100000;
      5'd16:   return 26'd200000;
      5'd17:   return 26'd500000;
      5'd18:   return 26'd1000000;
      5'd19:   return 26'd2000000;
      5'd20:   return 26'd5000000;
      5'd21:   return 26'd10000000;
      5'd22:   return 26'd20000000;
      default: return 26'd1;  // out-of-range index still yields a legal divisor
    endcase
  endfunction

  // Bit 0 is the up button, bit 1 the down button; both made active-high here.
  logic [1:0]      keyRaw;
  logic [1:0]      sync1, sync2, deb, debPrev;
  logic [DB_W-1:0] dbCnt [2];

  assign keyRaw = {~keyDn_n, ~keyUp_n};

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      debPrev  <= '0;
      dbCnt[0] <= '0;
      dbCnt[1] <= '0;
    end else begin
      sync1   <= keyRaw;
      sync2   <= sync1;
      debPrev <= deb;
      for (int b = 0; b < 2; b++) begin
        if (sync2[b] == deb[b]) begin
          dbCnt[b] <= '0;
        end else if (dbCnt[b] == DB_W'(DEBOUNCE_CYC - 1)) begin
          deb[b]   <= sync2[b];
          dbCnt[b] <= '0;
        end else begin
          dbCnt[b] <= dbCnt[b] + DB_W'(1);
        end
      end
    end
  end

  state_t          state, stateNext;
  logic            dirUp, dirUpNext;
  logic [HC_W-1:0] holdCnt, holdCntNext, holdLimit;
  logic            upRise, dnRise, heldBtn, otherBtn;
  logic            doStep, stepUp, loadDef;
  logic [4:0]      idxNext;

  assign upRise    = deb[0] & ~debPrev[0];
  assign dnRise    = deb[1] & ~debPrev[1];
  assign heldBtn   = dirUp ? deb[0] : deb[1];
  assign otherBtn  = dirUp ? deb[1] : deb[0];
  assign holdLimit = (state == HOLD) ? HC_W'(HOLD_CYC - 1) : HC_W'(REPEAT_CYC - 1);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    stateNext   = state;
    dirUpNext   = dirUp;
    holdCntNext = holdCnt;
    doStep      = 1'b0;
    stepUp      = dirUp;
    loadDef     = 1'b0;
    case (state)
      IDLE: begin
        if (deb[0] && deb[1]) begin
          stateNext = BOTH;
          loadDef   = 1'b1;
        end else if (upRise || dnRise) begin
          doStep      = 1'b1;
          stepUp      = upRise;
          dirUpNext   = upRise;
          holdCntNext = '0;
          stateNext   = HOLD;
        end
      end
      HOLD, REPEAT: begin
        if (otherBtn) begin
          stateNext = BOTH;
          loadDef   = 1'b1;
        end else if (!heldBtn) begin
          stateNext = IDLE;
        end else if (holdCnt == holdLimit) begin
          doStep      = 1'b1;
          holdCntNext = '0;
          stateNext   = REPEAT;
        end else begin
          holdCntNext = holdCnt + HC_W'(1);
        end
      end
      BOTH: begin
        if (!deb[0] && !deb[1]) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    idxNext = idx;
    if (loadDef) begin
      idxNext = DEF_IDX;
    end else if (doStep) begin
      if (stepUp && idx != 5'(MAX_IDX)) idxNext = idx + 5'd1;
      else if (!stepUp && idx != 5'd0)  idxNext = idx - 5'd1;
    end
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      dirUp   <= 1'b0;
      holdCnt <= '0;
      idx     <= DEF_IDX;
      freq    <= freqOf(DEF_IDX);
      chg     <= 1'b0;
      atMin   <= 1'b0;
      atMax   <= 1'b0;
    end else begin
      state   <= stateNext;
      dirUp   <= dirUpNext;
      holdCnt <= holdCntNext;
      idx     <= idxNext;
      freq    <= freqOf(idxNext);
      chg     <= (idxNext != idx);
      atMin   <= (idxNext == 5'd0);
      atMax   <= (idxNext == 5'(MAX_IDX));
    end
  end

endmodule
